// File: rtl/pingpong_ram_if.sv
// pingpong_ram_if: writer/reader handshake and data bus of the ping-pong frame RAM.
interface pingpong_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  wrEnIn;
    logic [ADDR_WIDTH-1:0] wrAddrIn;
    logic [DATA_WIDTH-1:0] wrDataIn;
    logic                  wrDoneIn;
    logic                  wrReadyOut;
    logic                  rdEnIn;
    logic [ADDR_WIDTH-1:0] rdAddrIn;
    logic                  rdDoneIn;
    logic                  rdReadyOut;
    logic [DATA_WIDTH-1:0] rdDataOut;
    logic                  rdValidOut;
    logic                  errOut;
    modport master (
        output wrEnIn, wrAddrIn, wrDataIn, wrDoneIn, rdEnIn, rdAddrIn, rdDoneIn,
        input  wrReadyOut, rdReadyOut, rdDataOut, rdValidOut, errOut
    );
    modport slave (
        input  wrEnIn, wrAddrIn, wrDataIn, wrDoneIn, rdEnIn, rdAddrIn, rdDoneIn,
        output wrReadyOut, rdReadyOut, rdDataOut, rdValidOut, errOut
    );
endinterface

// File: rtl/pingpong_ram.sv
// pingpong_ram: two-bank frame memory; writer fills one bank while the reader drains the other.
// Define PINGPONG_RAM_OUTREG_EN to add a second output register stage (read latency 2).
module pingpong_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input logic          clkIn,
    input logic          rstIn,
    pingpong_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    logic [DATA_WIDTH-1:0] r_mem [2*DEPTH];
    logic                  r_wrBank;
    logic                  r_rdBank;
    logic [1:0]            r_fullCnt;
    logic                  r_err;
    logic                  r_rdValid;
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  w_wrReady;
    logic                  w_rdReady;
    logic                  w_wrAcc;
    logic                  w_rdAcc;
    logic                  w_wrDoneAcc;
    logic                  w_rdDoneAcc;
    logic                  w_err;
    assign w_wrReady   = (r_fullCnt != 2'd2);
    assign w_rdReady   = (r_fullCnt != 2'd0);
    assign w_wrAcc     = bus.wrEnIn & w_wrReady;
    assign w_rdAcc     = bus.rdEnIn & w_rdReady;
    assign w_wrDoneAcc = bus.wrDoneIn & w_wrReady;
    assign w_rdDoneAcc = bus.rdDoneIn & w_rdReady;
    assign w_err       = ((bus.wrEnIn | bus.wrDoneIn) & ~w_wrReady)
                       | ((bus.rdEnIn | bus.rdDoneIn) & ~w_rdReady);
    assign bus.wrReadyOut = w_wrReady;
    assign bus.rdReadyOut = w_rdReady;
    assign bus.errOut     = r_err;
    always_ff @(posedge clkIn) begin
        if (w_wrAcc) r_mem[{r_wrBank, bus.wrAddrIn}] <= bus.wrDataIn;
    end
    // Accesses use the pre-toggle bank, so a strobe alongside its done lands in the finished frame.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_wrBank  <= 1'b0;
            r_rdBank  <= 1'b0;
            r_fullCnt <= 2'd0;
            r_err     <= 1'b0;
            r_rdValid <= 1'b0;
            r_rdData  <= '0;
        end else begin
            r_wrBank  <= r_wrBank ^ w_wrDoneAcc;
            r_rdBank  <= r_rdBank ^ w_rdDoneAcc;
            r_fullCnt <= r_fullCnt + {1'b0, w_wrDoneAcc} - {1'b0, w_rdDoneAcc};
            r_err     <= r_err | w_err;
            r_rdValid <= w_rdAcc;
            if (w_rdAcc) r_rdData <= r_mem[{r_rdBank, bus.rdAddrIn}];
        end
    end
`ifdef PINGPONG_RAM_OUTREG_EN
    logic                  r_rdValid2;
    logic [DATA_WIDTH-1:0] r_rdData2;
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_rdValid2 <= 1'b0;
            r_rdData2  <= '0;
        end else begin
            r_rdValid2 <= r_rdValid;
            r_rdData2  <= r_rdData;
        end
    end
    assign bus.rdValidOut = r_rdValid2;
    assign bus.rdDataOut  = r_rdData2;
`else
    assign bus.rdValidOut = r_rdValid;
    assign bus.rdDataOut  = r_rdData;
`endif
endmodule

// File: tb/tb_pingpong_ram.sv
// tb_pingpong_ram: frame-queue model of the ping-pong RAM checked every cycle, plus literal spot checks.
module tb_pingpong_ram;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int DEPTH = 2 ** AW;
`ifdef PINGPONG_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic [DW-1:0] d [DEPTH];
        bit            k [DEPTH];
    } frame_t;

    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;

    pingpong_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    pingpong_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clkIn(clk), .rstIn(rst), .bus(bus));

    always #5 clk = ~clk;

    frame_t        fq [$];
    frame_t        cur;
    bit            m_err;
    bit            pv [2];
    bit            pk [2];
    logic [DW-1:0] pd [2];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clear_cur();
        for (int i = 0; i < DEPTH; i++) cur.k[i] = 0;
    endtask

    // Frames handed to the reader wait in a queue; its size is the number of full banks.
    task automatic model_step();
        int n;
        bit wr_rdy, rd_rdy;
        if (rst) begin
            fq.delete();
            clear_cur();
            m_err = 0;
            for (int i = 0; i < 2; i++) begin pv[i] = 0; pk[i] = 0; end
            return;
        end
        n = fq.size();
        wr_rdy = n < 2;
        rd_rdy = n > 0;
        for (int i = LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pk[i] = pk[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = bus.rdEnIn && rd_rdy;
        pk[0] = 0;
        if (pv[0]) begin
            pd[0] = fq[0].d[bus.rdAddrIn];
            pk[0] = fq[0].k[bus.rdAddrIn];
        end
        if (bus.wrEnIn && wr_rdy) begin
            cur.d[bus.wrAddrIn] = bus.wrDataIn;
            cur.k[bus.wrAddrIn] = 1;
        end
        if (((bus.wrEnIn || bus.wrDoneIn) && !wr_rdy) || ((bus.rdEnIn || bus.rdDoneIn) && !rd_rdy))
            m_err = 1;
        if (bus.rdDoneIn && rd_rdy) void'(fq.pop_front());
        if (bus.wrDoneIn && wr_rdy) begin
            fq.push_back(cur);
            clear_cur();
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("wrReady", {31'b0, bus.wrReadyOut}, {31'b0, fq.size() < 2});
        chk("rdReady", {31'b0, bus.rdReadyOut}, {31'b0, fq.size() > 0});
        chk("err", {31'b0, bus.errOut}, {31'b0, m_err});
        chk("rdValid", {31'b0, bus.rdValidOut}, {31'b0, pv[LAT-1]});
        if (pv[LAT-1] && pk[LAT-1]) chk("rdData", bus.rdDataOut, pd[LAT-1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_frame(input logic [DW-1:0] base, input int n);
        for (int a = 0; a < n; a++) begin
            bus.wrEnIn = 1; bus.wrAddrIn = AW'(a); bus.wrDataIn = base + DW'(a);
            tick();
        end
        bus.wrEnIn = 0;
    endtask

    task automatic wr_done();
        bus.wrDoneIn = 1; tick(); bus.wrDoneIn = 0;
    endtask

    task automatic rd_done();
        bus.rdDoneIn = 1; tick(); bus.rdDoneIn = 0;
    endtask

    task automatic read1(input int a);
        bus.rdEnIn = 1; bus.rdAddrIn = AW'(a);
        tick();
        bus.rdEnIn = 0;
        repeat (LAT - 1) tick();
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0; tick();
    endtask

    initial begin
        rst = 1;
        bus.wrEnIn = 0; bus.wrAddrIn = '0; bus.wrDataIn = '0; bus.wrDoneIn = 0;
        bus.rdEnIn = 0; bus.rdAddrIn = '0; bus.rdDoneIn = 0;
        repeat (2) tick();
        chk("rst_wrReady", {31'b0, bus.wrReadyOut}, 32'd1);
        chk("rst_rdReady", {31'b0, bus.rdReadyOut}, 32'd0);
        chk("rst_rdData", bus.rdDataOut, 32'd0);
        chk("rst_rdValid", {31'b0, bus.rdValidOut}, 32'd0);
        rst = 0;
        tick();
        // single frame round trip
        write_frame(32'h100, 8);
        wr_done();
        chk("s1_rdReady", {31'b0, bus.rdReadyOut}, 32'd1);
        for (int a = 0; a < 8; a++) read1(a);
        read1(5);
        chk("s1_valid", {31'b0, bus.rdValidOut}, 32'd1);
        chk("s1_data", bus.rdDataOut, 32'h105);
        chk("s1_err", {31'b0, bus.errOut}, 32'd0);
        rd_done();
        chk("s1_rdReady_after", {31'b0, bus.rdReadyOut}, 32'd0);
        // two full frames, overflow write
        write_frame(32'h200, 8);
        wr_done();
        write_frame(32'h300, 8);
        wr_done();
        chk("s2_wrReady", {31'b0, bus.wrReadyOut}, 32'd0);
        chk("s2_err_pre", {31'b0, bus.errOut}, 32'd0);
        bus.wrEnIn = 1; bus.wrAddrIn = 4'd2; bus.wrDataIn = 32'hdead;
        tick();
        bus.wrEnIn = 0;
        chk("s2_err", {31'b0, bus.errOut}, 32'd1);
        read1(2);
        chk("s2_frameA", bus.rdDataOut, 32'h202);
        rd_done();
        read1(2);
        chk("s2_frameB", bus.rdDataOut, 32'h302);
        rd_done();
        do_reset();
        // simultaneous done at one full bank, last write coincident with done
        write_frame(32'h400, 8);
        wr_done();
        write_frame(32'h500, 7);
        bus.wrEnIn = 1; bus.wrAddrIn = 4'd7; bus.wrDataIn = 32'h507;
        bus.wrDoneIn = 1; bus.rdDoneIn = 1;
        tick();
        bus.wrEnIn = 0; bus.wrDoneIn = 0; bus.rdDoneIn = 0;
        chk("s3_rdReady", {31'b0, bus.rdReadyOut}, 32'd1);
        chk("s3_wrReady", {31'b0, bus.wrReadyOut}, 32'd1);
        read1(7);
        chk("s3_data7", bus.rdDataOut, 32'h507);
        read1(0);
        chk("s3_data0", bus.rdDataOut, 32'h500);
        chk("s3_err", {31'b0, bus.errOut}, 32'd0);
        do_reset();
        // read with nothing ready; dones together at empty
        read1(0);
        chk("s4_valid", {31'b0, bus.rdValidOut}, 32'd0);
        chk("s4_err", {31'b0, bus.errOut}, 32'd1);
        bus.wrDoneIn = 1; bus.rdDoneIn = 1;
        tick();
        bus.wrDoneIn = 0; bus.rdDoneIn = 0;
        chk("s4_rdReady", {31'b0, bus.rdReadyOut}, 32'd1);
        chk("s4_wrReady", {31'b0, bus.wrReadyOut}, 32'd1);
        // reset with a read in flight
        bus.rdEnIn = 1; bus.rdAddrIn = 4'd1;
        tick();
        bus.rdEnIn = 0;
        rst = 1;
        #1;
        chk("s5_valid", {31'b0, bus.rdValidOut}, 32'd0);
        chk("s5_data", bus.rdDataOut, 32'd0);
        chk("s5_rdReady", {31'b0, bus.rdReadyOut}, 32'd0);
        chk("s5_wrReady", {31'b0, bus.wrReadyOut}, 32'd1);
        chk("s5_err", {31'b0, bus.errOut}, 32'd0);
        tick();
        rst = 0;
        tick();
        chk("s5_post_wrReady", {31'b0, bus.wrReadyOut}, 32'd1);
        chk("s5_post_rdReady", {31'b0, bus.rdReadyOut}, 32'd0);
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/pingpong_ram.md
# pingpong_ram

Double-buffered (ping-pong) dual-port frame memory for the FFT datapath: two banks of `2**ADDR_WIDTH` words, one being filled by the writer while the other is drained by the reader. Bank ownership is swapped by a done/ready handshake on each side. It supersedes the single-bank dual-port RAM between FFT stages, where one stage must write a full frame in arbitrary (e.g. bit-reversed) order before the next reads it.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits
- ADDR_WIDTH, 10, per-bank address width; bank depth DEPTH = 2**ADDR_WIDTH

Ports:
- clkIn  input  1  single clock; all logic on rising edge
- rstIn  input  1  asynchronous, active-high reset
- wrEnIn  input  1  write strobe into current write bank
- wrAddrIn  input  ADDR_WIDTH  write address within bank
- wrDataIn  input  DATA_WIDTH  write data
- wrDoneIn  input  1  pulse: writer finished current frame, hand bank to reader
- wrReadyOut  output  1  a bank is owned by the writer
- rdEnIn  input  1  read strobe from current read bank
- rdAddrIn  input  ADDR_WIDTH  read address within bank
- rdDoneIn  input  1  pulse: reader finished frame, release bank to writer
- rdReadyOut  output  1  a full bank is owned by the reader
- rdDataOut  output  DATA_WIDTH  read data
- rdValidOut  output  1  rdDataOut valid this cycle
- errOut  output  1  sticky protocol-error flag

## Operation
- State: wrBankR (1b), rdBankR (1b), fullCntR (0..2, 2b). Memory is 2*DEPTH words, physical address {bank, addr}.
- wrReadyOut = (fullCntR != 2); rdReadyOut = (fullCntR != 0). Both are combinational from registered state only.
- Invariant: wrBankR == rdBankR exactly when fullCntR is 0 or 2.
- Write: wrEnIn && wrReadyOut writes wrDataIn to {wrBankR, wrAddrIn}. With !wrReadyOut the write is dropped.
- Read: rdEnIn && rdReadyOut reads {rdBankR, rdAddrIn}; rdValidOut follows with the pipeline latency. With !rdReadyOut there is no read and no valid.
- wrDoneIn && wrReadyOut: wrBankR toggles, fullCntR increments.
- rdDoneIn && rdReadyOut: rdBankR toggles, fullCntR decrements.
- Both accepted in the same cycle: both banks toggle and fullCntR is unchanged.
- Strobe coincident with done on the same side: the access uses the pre-toggle bank.
- Readiness is judged on pre-edge state. wrDoneIn at fullCntR==2 and rdDoneIn at fullCntR==0 are ignored even if the other side's done arrives in the same cycle.
- Writer and reader never share a bank while both are ready, so no read/write collision exists.
- errOut sets on any of the following and is cleared only by rstIn:
  - wrEnIn or wrDoneIn while !wrReadyOut
  - rdEnIn or rdDoneIn while !rdReadyOut

## Timing
- Reset (async assert, sync release): wrBankR=0, rdBankR=0, fullCntR=0. Outputs: wrReadyOut=1, rdReadyOut=0, rdDataOut=0, rdValidOut=0, errOut=0. Memory contents are not reset.
- Read latency is 1 cycle by default (registered output): strobe at edge N gives data and valid after edge N+1.
- wrReadyOut and rdReadyOut update on the edge that accepts a done.
  - A frame handed over at edge N is readable from cycle N+1.
  - A write issued after edge N at the same address appears in the next frame only.
- rstIn asserted mid-frame:
  - Pending read pipeline flushed, rdValidOut=0 immediately.
  - Partially written frame abandoned.

## Configuration
- PINGPONG_RAM_OUTREG_EN defined: adds a second output register stage for timing closure. Read latency is 2 cycles; rdValidOut is delayed to match. Both stages reset to 0.
- Undefined: single output register, latency 1.
- Handshake and bank behaviour are identical in both builds.

## Test plan
- Reset, write addr 0..7 = 0x100+addr, wrDoneIn, read 0..7 -> rdReadyOut=1 one cycle after done; rdDataOut = 0x100..0x107 at the configured latency; errOut=0.
- Two frames written back-to-back (A then B) with no reads -> fullCntR=2, wrReadyOut=0. A third write is dropped and sets errOut. Reads return frame A; after rdDoneIn they return frame B.
- wrDoneIn and rdDoneIn in the same cycle at fullCntR=1 -> both banks toggle, fullCntR stays 1. Next reads return the just-completed frame.
- rdEnIn at fullCntR=0 -> rdValidOut stays 0, errOut=1. rdDoneIn with wrDoneIn at fullCntR=0 -> only the write handover is taken, fullCntR=1.
- rstIn pulsed mid-read with a read in flight -> rdValidOut=0 and all outputs at reset values within the reset cycle. Post-reset wrReadyOut=1, rdReadyOut=0.
- Rebuild with PINGPONG_RAM_OUTREG_EN and rerun the first scenario -> identical data, latency 2 cycles.
